// File: rtl/sync_fifo_buffer_if.sv
// sync_fifo_buffer_if -- write/read request bundle for sync_fifo_buffer.
//
// Handshake: a write is taken on a rising clock edge when wr_en=1 and full=0.
// A read is taken on a rising clock edge when rd_en=1 and empty=0. The popped
// word appears on rd_data one cycle later, with rd_valid=1 for that one cycle.
// full/empty act as the ready signals, and rd_valid is the data-valid strobe.
// The requester can assert a request at any time. A request made against
// full or empty is dropped and is not retried.
//
// Signals:
//   wr_en, wr_data          requester -> fifo   write request and word
//   rd_en                   requester -> fifo   read request
//   rd_data, rd_valid       fifo -> requester   registered read word and strobe
//   full, empty             fifo -> requester   occupancy == DEPTH / == 0
//   almost_full/empty       fifo -> requester   threshold flags
//   count                   fifo -> requester   occupancy, 0..DEPTH
interface sync_fifo_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count
  );
endinterface

// File: rtl/sync_fifo_buffer.sv
// sync_fifo_buffer -- single-clock FIFO. Storage is a simple dual-port
// array, and the read port is registered.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   bus (slave)    wr_en/wr_data/rd_en in; rd_data/rd_valid/full/empty/
//                  almost_full/almost_empty/count out (see sync_fifo_buffer_if)
//   overflow_cnt   [15:0] saturating count of dropped writes   (SYNC_FIFO_STATS_EN)
//   underflow_cnt  [15:0] saturating count of dropped reads    (SYNC_FIFO_STATS_EN)
//
// Optional feature macro: SYNC_FIFO_STATS_EN adds the two drop counters.
//
// The status flags are registered. They are computed from the next occupancy,
// so they always agree with the count register in the same cycle. Reset does
// not clear the array. The pointers return to 0, so old words become
// unreachable.
module sync_fifo_buffer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                clk,
  input  logic                rst,
  sync_fifo_buffer_if.slave   bus
`ifdef SYNC_FIFO_STATS_EN
  ,
  output logic [15:0]         overflow_cnt,
  output logic [15:0]         underflow_cnt
`endif
);

  localparam int              DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Acceptance uses only the registered flags. When the FIFO is full, a
  // simultaneous read cannot free a slot for the write in the same edge.
  // Reset blocks both requests.
  assign w_wr_acc = bus.wr_en && !r_full  && !rst;
  assign w_rd_acc = bus.rd_en && !r_empty && !rst;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // The array has no reset, so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_rd_data      <= '0;
      r_rd_valid     <= 1'b0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      // Pointers are exactly ADDR_WIDTH bits wide, so they wrap from
      // DEPTH-1 to 0 without extra logic.
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      r_rd_valid     <= w_rd_acc;
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == LP_DEPTH);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= LP_AFULL);
      r_almost_empty <= (w_count_nxt <= LP_AEMPTY);
    end
  end

`ifdef SYNC_FIFO_STATS_EN
  logic [15:0] r_overflow_cnt;
  logic [15:0] r_underflow_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow_cnt  <= '0;
      r_underflow_cnt <= '0;
    end else begin
      if (bus.wr_en && r_full && (r_overflow_cnt != 16'hFFFF)) begin
        r_overflow_cnt <= r_overflow_cnt + 16'd1;
      end
      if (bus.rd_en && r_empty && (r_underflow_cnt != 16'hFFFF)) begin
        r_underflow_cnt <= r_underflow_cnt + 16'd1;
      end
    end
  end

  assign overflow_cnt  = r_overflow_cnt;
  assign underflow_cnt = r_underflow_cnt;
`endif

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.count        = r_count;

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// tb_sync_fifo_buffer -- directed test of sync_fifo_buffer with a queue-based
// reference model. Build with SYNC_FIFO_STATS_EN defined to cover the drop
// counters as well.
module tb_sync_fifo_buffer;

  localparam int DW     = 16;
  localparam int AW     = 4;
  localparam int DEPTH  = 2**AW;
  localparam int AFULL  = DEPTH - 4;
  localparam int AEMPTY = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef SYNC_FIFO_STATS_EN
  logic [15:0] overflow_cnt;
  logic [15:0] underflow_cnt;
`endif

  sync_fifo_buffer #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (AFULL),
    .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave)
`ifdef SYNC_FIFO_STATS_EN
    ,
    .overflow_cnt (overflow_cnt),
    .underflow_cnt(underflow_cnt)
`endif
  );

  // ---------------- scoreboard / checker ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It keeps the queued words in FIFO order and applies the
  // request rules to the occupancy as it stood before the edge.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [15:0]   m_ovf;
  logic [15:0]   m_unf;
  bit            m_init = 1'b0;

  function automatic void model_step();
    int n;
    n = exp_q.size();
    if (rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = '0;
      m_unf   = '0;
      m_init  = 1'b1;
      return;
    end
    m_valid = 1'b0;
    if (bus.rd_en) begin
      if (n > 0) begin
        m_data  = exp_q.pop_front();
        m_valid = 1'b1;
      end else if (m_unf != 16'hFFFF) begin
        m_unf = m_unf + 16'd1;
      end
    end
    if (bus.wr_en) begin
      if (n < DEPTH) exp_q.push_back(bus.wr_data);
      else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
    end
  endfunction

  always @(posedge clk) model_step();

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("m_count",  32'(bus.count),        32'(exp_q.size()));
      chk("m_full",   32'(bus.full),         32'(exp_q.size() == DEPTH));
      chk("m_empty",  32'(bus.empty),        32'(exp_q.size() == 0));
      chk("m_afull",  32'(bus.almost_full),  32'(exp_q.size() >= AFULL));
      chk("m_aempty", 32'(bus.almost_empty), 32'(exp_q.size() <= AEMPTY));
      chk("m_valid",  32'(bus.rd_valid),     32'(m_valid));
      chk("m_data",   32'(bus.rd_data),      32'(m_data));
`ifdef SYNC_FIFO_STATS_EN
      chk("m_ovf",    32'(overflow_cnt),     32'(m_ovf));
      chk("m_unf",    32'(underflow_cnt),    32'(m_unf));
`endif
    end
  end

  // ---------------- driver ----------------
  // This task is entered at a falling edge. It drives the request and then
  // returns at the next falling edge, after the rising edge has consumed it.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    @(negedge clk);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // reset state
    chk("rst_count",  32'(bus.count), 32'd0);
    chk("rst_empty",  32'(bus.empty), 32'd1);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_full",   32'(bus.full), 32'd0);
    chk("rst_afull",  32'(bus.almost_full), 32'd0);
    chk("rst_valid",  32'(bus.rd_valid), 32'd0);
    chk("rst_data",   32'(bus.rd_data), 32'd0);
    rst = 1'b0;

    // four writes, then four reads, each returned one cycle later
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0);
    chk("basic_count4", 32'(bus.count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, 1'b1);
      chk("basic_valid", 32'(bus.rd_valid), 32'd1);
      chk("basic_data",  32'(bus.rd_data), 32'(i));
    end
    step(1'b0, '0, 1'b0);
    chk("basic_empty", 32'(bus.empty), 32'd1);
    chk("basic_hold",  32'(bus.rd_data), 32'h0004);
    chk("basic_novalid", 32'(bus.rd_valid), 32'd0);

    // fill to DEPTH, then check almost_full at its threshold and drop one write
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b1, DW'(16'h0100 + k), 1'b0);
      if (k == AFULL - 2) chk("afull_below", 32'(bus.almost_full), 32'd0);
      if (k == AFULL - 1) chk("afull_at",    32'(bus.almost_full), 32'd1);
    end
    chk("fill_full",  32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'(DEPTH));
    step(1'b1, 16'hDEAD, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'(DEPTH));
`ifdef SYNC_FIFO_STATS_EN
    chk("ovf_cnt", 32'(overflow_cnt), 32'd1);
`endif

    // at full, a read and a write together: only the read is taken
    step(1'b1, 16'hBEEF, 1'b1);
    chk("fullrw_valid", 32'(bus.rd_valid), 32'd1);
    chk("fullrw_data",  32'(bus.rd_data), 32'h0100);
    chk("fullrw_count", 32'(bus.count), 32'(DEPTH - 1));
    chk("fullrw_full",  32'(bus.full), 32'd0);
    for (int k = 1; k < DEPTH; k++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_data", 32'(bus.rd_data), 32'(16'h0100 + k));
    end
    step(1'b0, '0, 1'b0);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // at empty, a read and a write together: only the write is taken
    step(1'b1, 16'h00AA, 1'b1);
    chk("emptyrw_valid", 32'(bus.rd_valid), 32'd0);
    chk("emptyrw_count", 32'(bus.count), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("emptyrw_data",  32'(bus.rd_data), 32'h00AA);
    chk("emptyrw_valid2", 32'(bus.rd_valid), 32'd1);

    // stream 3*DEPTH words with continuous reads and writes, so pointers wrap
    step(1'b1, 16'h2000, 1'b0);
    for (int k = 1; k <= 3 * DEPTH; k++) begin
      step(1'b1, DW'(16'h2000 + k), 1'b1);
      chk("stream_data",  32'(bus.rd_data), 32'(16'h2000 + k - 1));
      chk("stream_count", 32'(bus.count), 32'd1);
    end
    step(1'b0, '0, 1'b1);
    chk("stream_last", 32'(bus.rd_data), 32'(16'h2000 + 3 * DEPTH));

    // reset mid-operation with count=5 while requests are active
    for (int k = 0; k < 5; k++) step(1'b1, DW'(16'h0300 + k), 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    rst = 1'b1;
    step(1'b1, 16'h0077, 1'b1);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_empty", 32'(bus.empty), 32'd1);
    chk("midrst_valid", 32'(bus.rd_valid), 32'd0);
    rst = 1'b0;
    step(1'b0, '0, 1'b1);
    chk("unf_valid", 32'(bus.rd_valid), 32'd0);
`ifdef SYNC_FIFO_STATS_EN
    chk("unf_cnt", 32'(underflow_cnt), 32'd1);
`endif
    step(1'b1, 16'h0055, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("postrst_data",  32'(bus.rd_data), 32'h0055);
    chk("postrst_valid", 32'(bus.rd_valid), 32'd1);
    step(1'b0, '0, 1'b0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
